// File: rtl/traffic_light_fsm_param_if.sv
// traffic_light_fsm_param_if: control inputs and display/status outputs of the traffic-light controller.
interface traffic_light_fsm_param_if;
    logic       advance;
    logic       hold;
    logic [6:0] seg_out;
    logic [3:0] digit_out;
    logic [1:0] state_out;
    logic [7:0] remaining;
    modport master (
        output advance, hold,
        input  seg_out, digit_out, state_out, remaining
    );
    modport slave (
        input  advance, hold,
        output seg_out, digit_out, state_out, remaining
    );
endinterface

// File: rtl/traffic_light_fsm_param.sv
// traffic_light_fsm_param: timed RED->YELLOW->GREEN->GREEN_FLASH cycle driving a 4-digit multiplexed 7-seg display.
// COUNTDOWN_DISPLAY_EN: when defined, digit3 shows min(remaining, 9); otherwise digit3 stays dark.
module traffic_light_fsm_param #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int FLASH_DIV = 5_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int T_RED     = 4,
    parameter int T_YELLOW  = 2,
    parameter int T_GREEN   = 4,
    parameter int T_FLASH   = 3
) (
    input logic                        clk,
    input logic                        reset,
    traffic_light_fsm_param_if.slave   bus
);
    typedef enum logic [1:0] {RED, YELLOW, GREEN, GREEN_FLASH} state_e;
    localparam logic [6:0]  LIT        = 7'b1000000;
    localparam logic [6:0]  DARK       = 7'b1111111;
    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] FLASH_LAST = 32'(FLASH_DIV - 1);
    localparam logic [31:0] SCAN_LAST  = 32'(SCAN_DIV - 1);
    if (T_RED < 1 || T_RED > 255 || T_YELLOW < 1 || T_YELLOW > 255 ||
        T_GREEN < 1 || T_GREEN > 255 || T_FLASH < 1 || T_FLASH > 255) begin : g_bad_dur
        $error("traffic_light_fsm_param: state durations must be 1..255");
    end
    if (TICK_DIV < 1 || FLASH_DIV < 1 || SCAN_DIV < 1) begin : g_bad_div
        $error("traffic_light_fsm_param: dividers must be >= 1");
    end
`ifdef COUNTDOWN_DISPLAY_EN
    localparam logic [6:0] SEG7 [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
`endif
    function automatic logic [7:0] dur(input state_e s);
        return s == RED    ? 8'(T_RED)    :
               s == YELLOW ? 8'(T_YELLOW) :
               s == GREEN  ? 8'(T_GREEN)  : 8'(T_FLASH);
    endfunction
    state_e      state_q, state_d, nxt;
    logic [7:0]  rem_q, rem_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [31:0] flash_cnt_q, flash_cnt_d;
    logic [31:0] scan_cnt_q, scan_cnt_d;
    logic        phase_q, phase_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [6:0]  seg_q, seg_d, aux;
    logic [3:0]  dig_q, dig_d;
    logic        tick, expire, entry, flash_wrap, scan_wrap, lamp_on;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RED;
            rem_q       <= 8'(T_RED);
            tick_cnt_q  <= '0;
            flash_cnt_q <= '0;
            scan_cnt_q  <= '0;
            phase_q     <= 1'b1;
            digit_idx_q <= '0;
            seg_q       <= LIT;
            dig_q       <= 4'b1110;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            tick_cnt_q  <= tick_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            phase_q     <= phase_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end
    // advance and an expiring tick share one transition path, so they can never double-step
    always_comb begin
        tick        = tick_cnt_q == TICK_LAST;
        expire      = tick && !bus.hold && rem_q == 8'd1;
        nxt         = state_e'(state_q + 2'd1);
        state_d     = (bus.advance || expire) ? nxt : state_q;
        rem_d       = (bus.advance || expire) ? dur(nxt) :
                      (tick && !bus.hold)     ? rem_q - 8'd1 : rem_q;
        tick_cnt_d  = (bus.advance || tick) ? '0 : tick_cnt_q + 32'd1;
        entry       = state_d == GREEN_FLASH && state_q != GREEN_FLASH;
        flash_wrap  = flash_cnt_q == FLASH_LAST;
        flash_cnt_d = (entry || flash_wrap) ? '0 : flash_cnt_q + 32'd1;
        phase_d     = entry ? 1'b1 : flash_wrap ? ~phase_q : phase_q;
        scan_wrap   = scan_cnt_q == SCAN_LAST;
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 32'd1;
        digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
`ifdef COUNTDOWN_DISPLAY_EN
        aux         = SEG7[rem_q > 8'd9 ? 4'd9 : rem_q[3:0]];
`else
        aux         = DARK;
`endif
        lamp_on     = digit_idx_q == 2'd0 ? state_q == RED    :
                      digit_idx_q == 2'd1 ? state_q == YELLOW :
                      digit_idx_q == 2'd2 ? (state_q == GREEN || (state_q == GREEN_FLASH && phase_q)) : 1'b0;
        seg_d       = digit_idx_q == 2'd3 ? aux : lamp_on ? LIT : DARK;
        dig_d       = ~(4'b0001 << digit_idx_q);
    end
    assign bus.state_out = state_q;
    assign bus.remaining = rem_q;
    assign bus.seg_out   = seg_q;
    assign bus.digit_out = dig_q;
endmodule

// File: tb/tb_traffic_light_fsm_param.sv
// tb_traffic_light_fsm_param: scoreboard bench; a cycle-count reference model predicts every registered output.
module tb_traffic_light_fsm_param;
    localparam int TD = 4, FD = 3, SD = 2;
    localparam int DUR [4] = '{3, 1, 2, 2};
    localparam logic [6:0] LIT = 7'b1000000, DARK = 7'b1111111;
    localparam logic [6:0] SEG7 [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    typedef struct {
        int         st;
        int         rem;
        logic [6:0] seg;
        logic [3:0] dig;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    traffic_light_fsm_param_if bus();
    traffic_light_fsm_param #(
        .TICK_DIV(TD), .FLASH_DIV(FD), .SCAN_DIV(SD),
        .T_RED(3), .T_YELLOW(1), .T_GREEN(2), .T_FLASH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    exp_t q[$];
    exp_t me;
    int n_chk = 0, n_fail = 0;
    // model: state/remaining plus edges since reset (scan), since timer clear (tick), since flash entry
    int m_st, m_rem, m_n, m_m, m_j;
    function automatic logic [6:0] aux(input int r);
`ifdef COUNTDOWN_DISPLAY_EN
        return SEG7[r > 9 ? 9 : r];
`else
        return DARK;
`endif
    endfunction
    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction
    task automatic cyc(input logic r, input logic a, input logic h);
        exp_t e;
        int d, prev;
        bit lit, on, tick;
        @(negedge clk);
        reset = r;
        bus.advance = a;
        bus.hold = h;
        if (r) begin
            m_st = 0; m_rem = DUR[0]; m_n = 0; m_m = 0; m_j = 0;
            e = '{0, DUR[0], LIT, 4'b1110};
        end else begin
            d = (m_n / SD) % 4;
            lit = ((m_j / FD) % 2) == 0;
            on = d == 0 ? m_st == 0 : d == 1 ? m_st == 1 :
                 d == 2 ? (m_st == 2 || (m_st == 3 && lit)) : 1'b0;
            e.seg = d == 3 ? aux(m_rem) : on ? LIT : DARK;
            e.dig = ~(4'(1 << d));
            tick = (m_m % TD) == TD - 1;
            prev = m_st;
            if (a || (tick && !h && m_rem == 1)) begin
                m_st = (m_st + 1) % 4;
                m_rem = DUR[m_st];
            end else if (tick && !h) begin
                m_rem--;
            end
            m_m = a ? 0 : m_m + 1;
            m_j = (m_st == 3 && prev != 3) ? 0 : m_j + 1;
            m_n++;
            e.st = m_st;
            e.rem = m_rem;
        end
        q.push_back(e);
    endtask
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("state_out", int'(bus.state_out), me.st);
            chk("remaining", int'(bus.remaining), me.rem);
            chk("seg_out", int'(bus.seg_out), int'(me.seg));
            chk("digit_out", int'(bus.digit_out), int'(me.dig));
        end
    end
    initial begin
        logic h;
        bus.advance = 1'b0;
        bus.hold = 1'b0;
        repeat (2) cyc(1, 0, 0);
        repeat (70) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (20) cyc(0, 0, 1);
        repeat (12) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (11) cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (6) cyc(0, 0, 0);
        h = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 14) == 0) h = ~h;
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, h);
        end
        cyc(0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
